// File: rtl/relogio_pkg.sv
// Shared types and constants for the clock controller slice.
package relogio_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HORA = 2'd1,
        SET_MIN  = 2'd2
    } estado_t;

    localparam int unsigned TICK_DIV_PADRAO = 50_000_000;

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector for an already-synchronized button level.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic nivel,
    output logic borda
);

    logic anterior;
    logic armado;

    always_ff @(posedge clock) begin
        if (reset) begin
            anterior <= 1'b0;
            armado   <= 1'b0;
        end else begin
            anterior <= nivel;
            armado   <= 1'b1;
        end
    end

    // History is cleared in reset, so the first cycle after release is masked:
    // a button held through reset must not look like a fresh press.
    assign borda = armado & nivel & ~anterior;

endmodule

// File: rtl/ctrl_relogio.sv
// Clock controller: 1 s prescaler, RUN/SET_HORA/SET_MIN mode FSM, counter enables and blink gate.
module ctrl_relogio
    import relogio_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_PADRAO
) (
    input  logic       ctrl_clock,
    input  logic       ctrl_reset,
    input  logic       ctrl_btn_mode,
    input  logic       ctrl_btn_inc,
    input  logic       ctrl_minuto_carry,
    input  logic       ctrl_hora_carry,
    output logic       ctrl_enable_s,
    output logic       ctrl_enable_m,
    output logic       ctrl_enable_h,
    output logic       ctrl_clear_s,
    output logic [1:0] ctrl_state,
    output logic       ctrl_blink
);

    localparam int unsigned CW   = $clog2(TICK_DIV);
    localparam int unsigned MEIO = TICK_DIV / 2;

    if ((TICK_DIV % 2) != 0 || TICK_DIV < 4) begin : g_tick_div_invalido
        $error("ctrl_relogio: TICK_DIV must be even and >= 4");
    end

    estado_t       estado, estado_prox;
    logic [CW-1:0] presc;
    logic [CW-1:0] cnt_pisca;
    logic          tick;
    logic          borda_mode, borda_inc;
    logic          en_s_d, en_m_d, en_h_d, clr_d;

    detector_borda u_det_mode (
        .clock (ctrl_clock),
        .reset (ctrl_reset),
        .nivel (ctrl_btn_mode),
        .borda (borda_mode)
    );

    detector_borda u_det_inc (
        .clock (ctrl_clock),
        .reset (ctrl_reset),
        .nivel (ctrl_btn_inc),
        .borda (borda_inc)
    );

    assign tick = (presc == CW'(TICK_DIV - 1));

    // Mode edge has priority over everything else, including a tick in RUN.
    always_comb begin
        estado_prox = estado;
        en_s_d      = 1'b0;
        en_m_d      = 1'b0;
        en_h_d      = 1'b0;
        clr_d       = 1'b0;
        case (estado)
            RUN: begin
                if (borda_mode) begin
                    estado_prox = SET_HORA;
                    clr_d       = 1'b1;
                end else if (tick) begin
                    en_s_d = 1'b1;
                    en_m_d = ctrl_minuto_carry;
                    en_h_d = ctrl_minuto_carry & ctrl_hora_carry;
                end
            end
            SET_HORA: begin
                if (borda_mode) estado_prox = SET_MIN;
                else            en_h_d      = borda_inc;
            end
            SET_MIN: begin
                if (borda_mode) estado_prox = RUN;
                else            en_m_d      = borda_inc;
            end
            default: estado_prox = RUN;
        endcase
    end

    always_ff @(posedge ctrl_clock) begin
        if (ctrl_reset) begin
            estado        <= RUN;
            presc         <= '0;
            cnt_pisca     <= '0;
            ctrl_enable_s <= 1'b0;
            ctrl_enable_m <= 1'b0;
            ctrl_enable_h <= 1'b0;
            ctrl_clear_s  <= 1'b0;
            ctrl_blink    <= 1'b0;
        end else begin
            estado        <= estado_prox;
            ctrl_enable_s <= en_s_d;
            ctrl_enable_m <= en_m_d;
            ctrl_enable_h <= en_h_d;
            ctrl_clear_s  <= clr_d;

            if ((estado == SET_MIN && borda_mode) || tick) presc <= '0;
            else                                           presc <= presc + 1'b1;

            // Blink phase restarts on every entry into a set mode.
            if (estado_prox == RUN) begin
                ctrl_blink <= 1'b0;
                cnt_pisca  <= '0;
            end else if (estado_prox != estado) begin
                ctrl_blink <= 1'b1;
                cnt_pisca  <= '0;
            end else if (cnt_pisca == CW'(MEIO - 1)) begin
                ctrl_blink <= ~ctrl_blink;
                cnt_pisca  <= '0;
            end else begin
                cnt_pisca <= cnt_pisca + 1'b1;
            end
        end
    end

    assign ctrl_state = estado;

endmodule
